// File: rtl/data_store_buffer_pkg.sv
// Shared definitions for the data store buffer: default geometry, the
// strobe-width derivation and the layout of one buffered store entry.
package data_store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;
    localparam int SB_SW    = SB_DW / 8;

    // One byte strobe per data byte.
    function automatic int sb_strb_w(input int dw);
        return dw / 8;
    endfunction

    // One committed store waiting to be written to the data SRAM.
    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_SW-1:0] wstrb;
        logic [SB_DW-1:0] wdata;
    } sb_entry_t;

endpackage

// File: rtl/data_store_buffer_fwd_merge.sv
// Store-to-load forwarding network. For each byte of the load word it picks
// the youngest store that hits the same word with that strobe bit set.
// Buffered entries are scanned oldest-to-youngest from the head slot, then
// the store being pushed this cycle (the youngest of all) is applied last,
// so each later hit simply overwrites an earlier one.
module sbuf_fwd_merge
    import data_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW,
    parameter int SW    = SB_SW
) (
    input  logic [AW-1:0]          i_ent_addr [DEPTH],
    input  logic [SW-1:0]          i_ent_strb [DEPTH],
    input  logic [DW-1:0]          i_ent_data [DEPTH],
    input  logic [DEPTH-1:0]       i_ent_valid,
    input  logic [$clog2(DEPTH)-1:0] i_head,
    input  logic                   i_push,
    input  logic [AW-1:0]          i_push_addr,
    input  logic [SW-1:0]          i_push_strb,
    input  logic [DW-1:0]          i_push_data,
    input  logic [AW-1:0]          i_ld_addr,
    output logic [SW-1:0]          o_mask,
    output logic [DW-1:0]          o_data
);

    localparam int IW  = $clog2(DEPTH);
    localparam int OFS = $clog2(SW);
    // Keeps only the word-address bits; byte-offset bits are ignored.
    localparam logic [AW-1:0] WORD_MASK = {AW{1'b1}} << OFS;

    function automatic logic same_word(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return ((a ^ b) & WORD_MASK) == {AW{1'b0}};
    endfunction

    logic [IW-1:0] w_slot;
    logic          w_word_hit;
    logic          w_byte_hit;
    logic [SW-1:0] w_mask;
    logic [DW-1:0] w_data;

    // Youngest-wins per-byte selection across buffered entries and the live push.
    always_comb begin
        w_mask     = '0;
        w_data     = '0;
        w_slot     = i_head;
        w_word_hit = 1'b0;
        w_byte_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            w_slot     = i_head + IW'(k);
            w_word_hit = i_ent_valid[w_slot] && same_word(i_ent_addr[w_slot], i_ld_addr);
            for (int b = 0; b < SW; b++) begin
                w_byte_hit       = w_word_hit && i_ent_strb[w_slot][b];
                w_mask[b]        = w_mask[b] | w_byte_hit;
                w_data[8*b +: 8] = w_byte_hit ? i_ent_data[w_slot][8*b +: 8] : w_data[8*b +: 8];
            end
        end
        w_word_hit = i_push && same_word(i_push_addr, i_ld_addr);
        for (int b = 0; b < SW; b++) begin
            w_byte_hit       = w_word_hit && i_push_strb[b];
            w_mask[b]        = w_mask[b] | w_byte_hit;
            w_data[8*b +: 8] = w_byte_hit ? i_push_data[8*b +: 8] : w_data[8*b +: 8];
        end
    end

    assign o_mask = w_mask;
    assign o_data = w_data;

endmodule

// File: rtl/data_store_buffer.sv
// Data store buffer between MEM (committed stores) and the data SRAM.
// Stores queue in a circular FIFO and drain to the SRAM whenever no load
// needs the port, the buffer is full, or a fence forces it. Loads read the
// SRAM and get newer buffered bytes forwarded on top one cycle later.
module data_store_buffer
    import data_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW,
    localparam int SW   = sb_strb_w(DW)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [SW-1:0] st_wstrb,
    input  logic [DW-1:0] st_wdata,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_ready,
    output logic          ld_rdata_valid,
    output logic [DW-1:0] ld_rdata,
    input  logic          fence,
    output logic          sb_empty,
    output logic          data_sram_en,
    output logic [SW-1:0] data_sram_we,
    output logic [AW-1:0] data_sram_addr,
    output logic [DW-1:0] data_sram_wdata,
    input  logic [DW-1:0] data_sram_rdata
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    // FIFO state: pointers carry one extra wrap bit to tell full from empty.
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [DEPTH-1:0] r_valid;
    logic [AW-1:0]    r_ent_addr [DEPTH];
    logic [SW-1:0]    r_ent_strb [DEPTH];
    logic [DW-1:0]    r_ent_data [DEPTH];

    // Load pipeline: forwarding result captured at issue, merged next cycle.
    logic             r_rvalid;
    logic [SW-1:0]    r_fwd_mask;
    logic [DW-1:0]    r_fwd_data;
    logic             r_sb_empty;

    logic [IW-1:0]    w_head_idx;
    logic [IW-1:0]    w_tail_idx;
    logic [PW-1:0]    w_head_nxt;
    logic [PW-1:0]    w_tail_nxt;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_drain;
    logic             w_issue;
    logic [DEPTH-1:0] w_set;
    logic [DEPTH-1:0] w_clr;
    logic [SW-1:0]    w_fwd_mask;
    logic [DW-1:0]    w_fwd_data;
    logic [DW-1:0]    w_ld_rdata;

    assign w_head_idx = r_head[IW-1:0];
    assign w_tail_idx = r_tail[IW-1:0];
    assign w_empty    = (r_head == r_tail);
    assign w_full     = (r_head[IW] != r_tail[IW]) && (w_head_idx == w_tail_idx);

    assign st_ready   = !w_full;
    assign ld_ready   = !(!w_empty && (w_full || fence));
    assign w_push     = st_valid && st_ready;
    // A load only owns the SRAM port while out of reset; this keeps the port idle during reset.
    assign w_issue    = resetn && ld_req && ld_ready;
    // Drain and load issue are mutually exclusive: a drain needs either no load
    // request or a full/fence condition, and the latter also stalls loads.
    assign w_drain    = !w_empty && (w_full || fence || !ld_req);

    assign w_head_nxt = r_head + {{IW{1'b0}}, w_drain};
    assign w_tail_nxt = r_tail + {{IW{1'b0}}, w_push};
    assign w_set      = {{(DEPTH-1){1'b0}}, w_push}  << w_tail_idx;
    assign w_clr      = {{(DEPTH-1){1'b0}}, w_drain} << w_head_idx;

    // Single SRAM port: a drain writes the head entry, otherwise an issued load reads.
    always_comb begin
        data_sram_en    = w_drain | w_issue;
        data_sram_we    = '0;
        data_sram_addr  = ld_addr;
        data_sram_wdata = '0;
        if (w_drain) begin
            data_sram_we    = r_ent_strb[w_head_idx];
            data_sram_addr  = r_ent_addr[w_head_idx];
            data_sram_wdata = r_ent_data[w_head_idx];
        end else begin
            data_sram_addr  = ld_addr;
        end
    end

    // Pointer, occupancy and empty-status registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_valid    <= '0;
            r_sb_empty <= 1'b1;
        end else begin
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_valid    <= (r_valid & ~w_clr) | w_set;
            r_sb_empty <= (w_head_nxt == w_tail_nxt);
        end
    end

    // Entry storage: an accepted push writes the slot at the tail.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent_addr[i] <= '0;
                r_ent_strb[i] <= '0;
                r_ent_data[i] <= '0;
            end
        end else if (w_push) begin
            r_ent_addr[w_tail_idx] <= st_addr;
            r_ent_strb[w_tail_idx] <= st_wstrb;
            r_ent_data[w_tail_idx] <= st_wdata;
        end
    end

    sbuf_fwd_merge #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .SW    (SW)
    ) u_fwd_merge (
        .i_ent_addr  (r_ent_addr),
        .i_ent_strb  (r_ent_strb),
        .i_ent_data  (r_ent_data),
        .i_ent_valid (r_valid),
        .i_head      (w_head_idx),
        .i_push      (w_push),
        .i_push_addr (st_addr),
        .i_push_strb (st_wstrb),
        .i_push_data (st_wdata),
        .i_ld_addr   (ld_addr),
        .o_mask      (w_fwd_mask),
        .o_data      (w_fwd_data)
    );

    // Capture the forwarding decision at issue so the next cycle only merges.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rvalid   <= 1'b0;
            r_fwd_mask <= '0;
            r_fwd_data <= '0;
        end else begin
            r_rvalid <= w_issue;
            if (w_issue) begin
                r_fwd_mask <= w_fwd_mask;
                r_fwd_data <= w_fwd_data;
            end
        end
    end

    // Assemble the load result: forwarded bytes win, the rest come from SRAM.
    always_comb begin
        w_ld_rdata = '0;
        for (int b = 0; b < SW; b++) begin
            w_ld_rdata[8*b +: 8] = r_fwd_mask[b] ? r_fwd_data[8*b +: 8] : data_sram_rdata[8*b +: 8];
        end
    end

    assign ld_rdata_valid = r_rvalid;
    assign ld_rdata       = r_rvalid ? w_ld_rdata : '0;
    assign sb_empty       = r_sb_empty;

endmodule

// File: tb/tb_data_store_buffer.sv
// Self-checking bench for data_store_buffer. The reference model holds the
// pending stores as an ordered queue and the SRAM as a sparse word memory;
// a load's expected value is the coherent memory view (SRAM word with every
// older pending store applied in program order).
module tb_data_store_buffer;
    import data_store_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        resetn;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_ready;
    logic        ld_rdata_valid;
    logic [31:0] ld_rdata;
    logic        fence;
    logic        sb_empty;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    data_store_buffer dut (
        .clk             (clk),
        .resetn          (resetn),
        .st_valid        (st_valid),
        .st_ready        (st_ready),
        .st_addr         (st_addr),
        .st_wstrb        (st_wstrb),
        .st_wdata        (st_wdata),
        .ld_req          (ld_req),
        .ld_addr         (ld_addr),
        .ld_ready        (ld_ready),
        .ld_rdata_valid  (ld_rdata_valid),
        .ld_rdata        (ld_rdata),
        .fence           (fence),
        .sb_empty        (sb_empty),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    sb_entry_t   q[$];
    logic [31:0] mem [int unsigned];
    logic        pend_valid = 1'b0;
    logic [31:0] pend_data  = 32'h0;
    logic [31:0] last_rdata = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input int unsigned k);
        if (mem.exists(k)) return mem[k];
        else return (k * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] apply(input logic [31:0] v, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] r;
        r = v;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // One clock of stimulus, comparison against the model, and model update.
    task automatic cycle(input logic sv, input logic [31:0] sa, input logic [3:0] ss,
                         input logic [31:0] sd, input logic lr, input logic [31:0] la,
                         input logic fe);
        logic full, empty, e_st_ready, e_ld_ready, push, issue, drain;
        logic [31:0] v, rnext;
        int unsigned k;
        @(negedge clk);
        st_valid = sv; st_addr = sa; st_wstrb = ss; st_wdata = sd;
        ld_req = lr; ld_addr = la; fence = fe;
        #1;
        full       = (q.size() == DEPTH);
        empty      = (q.size() == 0);
        e_st_ready = !full;
        e_ld_ready = !(!empty && (full || fe));
        push       = sv && e_st_ready;
        issue      = lr && e_ld_ready;
        drain      = !empty && (full || fe || !lr);
        chk("st_ready", st_ready, e_st_ready);
        chk("ld_ready", ld_ready, e_ld_ready);
        chk("sb_empty", sb_empty, empty);
        chk("ld_rdata_valid", ld_rdata_valid, pend_valid);
        if (pend_valid) begin
            chk("ld_rdata", ld_rdata, pend_data);
            last_rdata = ld_rdata;
        end
        chk("sram_en", data_sram_en, drain || issue);
        chk("sram_we", data_sram_we, drain ? q[0].wstrb : 4'h0);
        if (drain) begin
            chk("drain_addr", data_sram_addr, q[0].addr);
            chk("drain_wdata", data_sram_wdata, q[0].wdata);
        end else if (issue) begin
            chk("load_addr", data_sram_addr, la);
        end
        k = la[31:2];
        v = mem_rd(k);
        foreach (q[i]) if (q[i].addr[31:2] == la[31:2]) v = apply(v, q[i].wstrb, q[i].wdata);
        if (push && sa[31:2] == la[31:2]) v = apply(v, ss, sd);
        rnext = issue ? mem_rd(k) : $urandom;
        @(posedge clk);
        pend_valid = issue;
        pend_data  = v;
        if (drain) begin
            mem[q[0].addr[31:2]] = apply(mem_rd(q[0].addr[31:2]), q[0].wstrb, q[0].wdata);
            void'(q.pop_front());
        end
        if (push) q.push_back('{addr: sa, wstrb: ss, wdata: sd});
        #1;
        data_sram_rdata = rnext;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 20 && q.size() != 0; i++)
            cycle(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        idle(1);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_st_ready"}, st_ready, 1'b1);
        chk({tag, "_ld_ready"}, ld_ready, 1'b1);
        chk({tag, "_sram_en"}, data_sram_en, 1'b0);
        chk({tag, "_sram_we"}, data_sram_we, 4'h0);
        chk({tag, "_ld_rdata"}, ld_rdata, 32'h0);
        chk({tag, "_rvalid"}, ld_rdata_valid, 1'b0);
        chk({tag, "_sb_empty"}, sb_empty, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; st_valid = 1'b0; st_addr = 32'h0; st_wstrb = 4'h0; st_wdata = 32'h0;
        ld_req = 1'b1; ld_addr = 32'h0; fence = 1'b0; data_sram_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        reset_checks("rst");
        ld_req = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // Simple forward: full-word store, load the next cycle, SRAM returns 0.
        mem[32'h100 >> 2] = 32'h0;
        cycle(1'b1, 32'h100, 4'hF, 32'hAABBCCDD, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h100, 1'b0);
        cycle(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("fwd_full_word", last_rdata, 32'hAABBCCDD);
        drain_all();

        // Partial strobes: youngest store wins per byte, rest from SRAM.
        mem[32'h200 >> 2] = 32'h55667788;
        cycle(1'b1, 32'h200, 4'h1, 32'h00000011, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h200, 4'h3, 32'h00002222, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h202, 1'b0);
        cycle(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("fwd_partial", last_rdata, 32'h55662222);
        drain_all();

        // Fill with loads pending: the full buffer drains and stalls loads.
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 32'h400 + 32'(4*i), 4'hF, $urandom, 1'b1, 32'h404, 1'b0);
        chk("full_after_fill", st_ready, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h408, 1'b0);
        drain_all();

        // Push and drain every cycle across several pointer wraps.
        cycle(1'b1, 32'h600, 4'hF, 32'h01010101, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 32'h600 + 32'(4*i), 4'hF, $urandom, 1'b0, 32'h0, 1'b0);
        drain_all();

        // Fence with three entries: three back-to-back writes, loads stalled.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h700 + 32'(4*i), 4'hF, $urandom, 1'b1, 32'h800, 1'b0);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h700, 1'b1);
        idle(1);

        // Randomized traffic over a small address window to provoke forwarding.
        for (int i = 0; i < 400; i++)
            cycle(($urandom % 3) != 0, 32'h100 + 32'(4*($urandom % 4)) + 32'($urandom % 4),
                  4'($urandom), $urandom, 1'($urandom % 2),
                  32'h100 + 32'(4*($urandom % 4)) + 32'($urandom % 4), ($urandom % 8) == 0);
        drain_all();

        // Reset with two stores buffered and a load in flight.
        cycle(1'b1, 32'h300, 4'hF, 32'h12345678, 1'b1, 32'h304, 1'b0);
        cycle(1'b1, 32'h304, 4'hF, 32'h9ABCDEF0, 1'b1, 32'h300, 1'b0);
        cycle(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h300, 1'b0);
        @(negedge clk);
        resetn = 1'b0; st_valid = 1'b1; ld_req = 1'b1;
        #1;
        reset_checks("midrst");
        @(negedge clk);
        st_valid = 1'b0; ld_req = 1'b0; fence = 1'b0;
        resetn = 1'b1;
        q.delete();
        pend_valid = 1'b0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_store_buffer.md
DATA_STORE_BUFFER -- requirements
Module: data_store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the store-entry count; legal values are powers of two from 2 to 16.
REQ-002 Parameter AW, default 32, SHALL set the byte-address width.
REQ-003 Parameter DW, default 32, SHALL set the data width; SW = DW/8 is the strobe width.
REQ-004 Ports SHALL be: clk in 1 clock; resetn in 1 async active-low reset.
REQ-005 st_valid in 1, st_ready out 1, st_addr in AW, st_wstrb in SW, st_wdata in DW: committed-store push from MEM.
REQ-006 ld_req in 1, ld_addr in AW, ld_ready out 1: load issue from ID; issue occurs when ld_req&&ld_ready.
REQ-007 ld_rdata_valid out 1, ld_rdata out DW: merged load result.
REQ-008 fence in 1, sb_empty out 1: force drain, buffer-empty status.
REQ-009 data_sram_en out 1, data_sram_we out SW, data_sram_addr out AW, data_sram_wdata out DW, data_sram_rdata in DW: single-port SRAM with 1-cycle read latency.

Function
REQ-010 Buffer SHALL be a circular FIFO with head/tail pointers of log2(DEPTH)+1 bits; full = MSBs differ and indices equal; empty = pointers equal.
REQ-011 st_ready SHALL equal !full; a push occurs when st_valid&&st_ready and writes entry{addr,wstrb,wdata} at tail.
REQ-012 Drain SHALL occur when the buffer is non-empty and (full || fence || !ld_req); it writes the head entry to SRAM (en=1, we=wstrb, addr, wdata) and advances head.
REQ-013 ld_ready SHALL equal !(non-empty && (full || fence)); on issue, SRAM sees en=1, we=0, addr=ld_addr, and no drain occurs that cycle.
REQ-014 Load issued in cycle T SHALL assert ld_rdata_valid in T+1 only; ld_rdata is assembled per byte.
REQ-015 The source for each ld_rdata byte SHALL be the youngest match at cycle T, where a match has the same word address (addr[AW-1:log2 SW]) and a set strobe bit.
REQ-016 Candidate matches SHALL be the buffered entries and any push accepted in cycle T; the T push is youngest.
REQ-017 Any byte with no match SHALL take data_sram_rdata.
REQ-018 Forwarded bytes and the byte mask SHALL be registered at T so that T+1 logic sees only mask, data and SRAM data.
REQ-019 Simultaneous push and drain SHALL be legal: count is unchanged and both pointers advance.
REQ-020 A push while full SHALL be impossible (st_ready=0); the same-cycle drain still frees one entry for the next cycle.
REQ-021 Pointer wrap at DEPTH SHALL toggle the MSB with no entry loss.
REQ-022 sb_empty SHALL be registered and equal 1 exactly when the buffer holds no entries after the current edge.
REQ-023 fence held high SHALL drain one entry per cycle until sb_empty=1; loads stall throughout.
REQ-024 At most one SRAM access SHALL occur per cycle, and data_sram_we SHALL be 0 whenever no drain occurs.

Reset
REQ-025 Asserting resetn=0 SHALL asynchronously clear pointers, ld_rdata_valid, forward mask/data, and entry valid state, and SHALL set sb_empty=1.
REQ-026 During reset, outputs SHALL be: st_ready=1, ld_ready=1, data_sram_en=0, data_sram_we=0, ld_rdata=0.
REQ-027 Reset mid-drain or mid-load SHALL discard all buffered stores and any pending ld_rdata_valid; no SRAM write follows deassertion.

Structure
REQ-028 A shared package SHALL hold the DEPTH/AW/DW defaults, the SW derivation, and the entry struct {addr, wstrb, wdata}.
REQ-029 A single combinational sub-module, sbuf_fwd_merge, SHALL perform the youngest-first per-byte match and produce the mask and forwarded data.

Verification
REQ-030 Store 0x100/0xF/0xAABBCCDD, then load 0x100 next cycle with SRAM returning 0 -> ld_rdata=0xAABBCCDD in the following cycle and no SRAM write yet.
REQ-031 Stores 0x200/0x1/0x00000011 then 0x200/0x3/0x00002222; load 0x202 with SRAM=0x55667788 -> ld_rdata=0x55662222.
REQ-032 Fill DEPTH=4 stores with ld_req held high -> st_ready=0 after the 4th push; drains occur one per cycle with ld_ready=0; the load issues when the buffer is no longer full.
REQ-033 Push and drain every cycle for 20 cycles -> count stays constant across ≥2 pointer wraps; the SRAM write order matches the push order.
REQ-034 Set fence=1 with 3 entries -> 3 consecutive SRAM writes, then sb_empty=1; ld_ready=0 until then.
REQ-035 Assert resetn=0 with 2 entries and a load in flight -> no ld_rdata_valid and no SRAM write after release; sb_empty=1.
